// File: rtl/sampadcacc_mc_if.sv
// Wishbone register-bus bundle for sampadcacc_mc: 8-bit data, 16-bit address,
// zero-wait slave.
interface sampadcacc_mc_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [15:0] wb_adr_i;
  logic [7:0]  wb_dat_i;
  logic [7:0]  wb_dat_o;
  logic        wb_ack_o;

  modport master (output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
                  input  wb_dat_o, wb_ack_o);
  modport slave  (input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
                  output wb_dat_o, wb_ack_o);
endinterface

// File: rtl/sampadcacc_mc.sv
// Multi-channel ADC window accumulator: sums NUM_CH channels per window, snapshots
// at window end and drains enabled channels as saturated fields into 32-bit entries.
module sampadcacc_mc #(
  parameter int NUM_CH   = 4,
  parameter int ADC_BITS = 8,
  parameter int SUM_BITS = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH*ADC_BITS-1:0] adc_data,
  input  logic                       adc_valid,
  input  logic                       sq_active,
  output logic [31:0]                sample,
  output logic                       sample_avail,
  sampadcacc_mc_if.slave             wb
);
  localparam int ACC_W = SUM_BITS + 1;
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  function automatic logic [PTR_W-1:0] lowest_bit(input logic [NUM_CH-1:0] m);
    lowest_bit = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) lowest_bit = PTR_W'(i);
  endfunction

  // Returns p itself when no higher bit is set, which marks the last channel.
  function automatic logic [PTR_W-1:0] next_bit(input logic [NUM_CH-1:0] m,
                                                input logic [PTR_W-1:0]  p);
    next_bit = p;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i] && (i > int'(p))) next_bit = PTR_W'(i);
  endfunction

  function automatic logic [31:0] sat_field(input  logic signed [ACC_W-1:0] v,
                                            input  logic [4:0]              w,
                                            output logic                    o,
                                            output logic                    u);
    logic [31:0] lim;
    lim = (32'd1 << w) - 32'd1;
    o = 1'b0;
    u = 1'b0;
    if (v < 0) begin
      sat_field = '0;
      u = 1'b1;
    end else if (32'($unsigned(v)) > lim) begin
      sat_field = lim;
      o = 1'b1;
    end else begin
      sat_field = 32'($unsigned(v)) & lim;
    end
  endfunction

  logic              enable, do_add, ovf, unf, overrun;
  logic [7:0]        acc_cnt, win_cnt;
  logic [4:0]        fw, fps, fld_cnt;
  logic [NUM_CH-1:0] ch_mask;
  logic [15:0]       init;

  logic signed [ACC_W-1:0] init_ext;
  logic signed [ACC_W-1:0] acc      [NUM_CH];
  logic signed [ACC_W-1:0] acc_next [NUM_CH];
  logic signed [ACC_W-1:0] hold     [NUM_CH];

  state_t           state, state_d;
  logic [PTR_W-1:0] ptr, ptr_d, lo_ptr, nxt_ptr;
  logic             last, win_end, accept, deposit;
  logic             f_ovf, f_unf, ovf_set, unf_set, overrun_set;
  logic [31:0]      field;

  logic       wr, cfg_wr, unused_adr;
  logic [2:0] adr;

  assign wr         = wb.wb_cyc_i && wb.wb_stb_i && wb.wb_we_i;
  assign cfg_wr     = wr && !sq_active;
  assign adr        = wb.wb_adr_i[2:0];
  assign unused_adr = ^wb.wb_adr_i[15:3];
  assign wb.wb_ack_o = 1'b1;

  assign init_ext = ACC_W'($signed(init));
  assign win_end  = sq_active && adc_valid && (win_cnt == acc_cnt);
  assign lo_ptr   = lowest_bit(ch_mask);
  assign nxt_ptr  = next_bit(ch_mask, ptr);
  assign last     = (nxt_ptr == ptr);

  // A window's first strobe (or plain mode) restarts from the signed offset.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      acc_next[c] = (((win_cnt == 8'd0) || !do_add) ? init_ext : acc[c])
                  + ACC_W'($signed({1'b0, adc_data[c*ADC_BITS +: ADC_BITS]}));
  end

  always_ff @(posedge clk) begin
    if (adc_valid) acc <= acc_next;
    if (accept)    hold <= acc_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    if (!sq_active) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:
          if (accept && (|ch_mask)) begin
            state_d = DRAIN;
            ptr_d   = lo_ptr;
          end
        DRAIN:
          if (!last)       ptr_d = nxt_ptr;
          else if (accept) ptr_d = lo_ptr;
          else             state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    accept      = win_end && ((state == IDLE) || ((state == DRAIN) && last));
    overrun_set = win_end && !accept;
    deposit     = sq_active && (state == DRAIN);
    field       = sat_field(hold[ptr], fw, f_ovf, f_unf);
    ovf_set     = deposit && f_ovf;
    unf_set     = deposit && f_unf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt      <= '0;
      fld_cnt      <= '0;
      sample       <= '0;
      sample_avail <= 1'b0;
    end else begin
      sample_avail <= 1'b0;
      if (!sq_active)     win_cnt <= '0;
      else if (adc_valid) win_cnt <= win_end ? 8'd0 : win_cnt + 8'd1;
      if (!sq_active) begin
        fld_cnt <= '0;
      end else if (deposit) begin
        sample <= (sample << fw) | field;
        if (fld_cnt == fps) begin
          fld_cnt      <= '0;
          sample_avail <= enable;
        end else begin
          fld_cnt <= fld_cnt + 5'd1;
        end
      end
    end
  end

  // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable  <= 1'b0;
      do_add  <= 1'b0;
      acc_cnt <= '0;
      fw      <= 5'd8;
      fps     <= 5'd3;
      ch_mask <= NUM_CH'(1);
      init    <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (cfg_wr) begin
        case (adr)
          3'd0: {do_add, enable} <= wb.wb_dat_i[1:0];
          3'd1: acc_cnt <= wb.wb_dat_i;
          3'd2: fw      <= (wb.wb_dat_i[4:0] == 5'd0) ? 5'd16 : wb.wb_dat_i[4:0];
          3'd3: fps     <= wb.wb_dat_i[4:0];
          3'd4: ch_mask <= wb.wb_dat_i[NUM_CH-1:0];
          3'd5: init[7:0]  <= wb.wb_dat_i;
          3'd6: init[15:8] <= wb.wb_dat_i;
          default: ;
        endcase
      end
      ovf     <= ovf_set     || (ovf     && !(wr && (adr == 3'd0) && wb.wb_dat_i[4]));
      unf     <= unf_set     || (unf     && !(wr && (adr == 3'd0) && wb.wb_dat_i[5]));
      overrun <= overrun_set || (overrun && !(wr && (adr == 3'd0) && wb.wb_dat_i[6]));
    end
  end

  always_comb begin
    wb.wb_dat_o = 8'h00;
    case (adr)
      3'd0: wb.wb_dat_o = {1'b0, overrun, unf, ovf, 2'b00, do_add, enable};
      3'd1: wb.wb_dat_o = acc_cnt;
      3'd2: wb.wb_dat_o = {3'b000, fw};
      3'd3: wb.wb_dat_o = {3'b000, fps};
      3'd4: wb.wb_dat_o = 8'(ch_mask);
      3'd5: wb.wb_dat_o = init[7:0];
      3'd6: wb.wb_dat_o = init[15:8];
      default: ;
    endcase
  end
endmodule

// File: tb/tb_sampadcacc_mc.sv
// Directed bench for sampadcacc_mc: register defaults, fill, summing, saturation,
// multi-channel drain, overrun, abort and asynchronous reset.
module tb_sampadcacc_mc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        sq_active = 1'b0;
  logic [31:0] sample;
  logic        sample_avail;
  int          checks = 0;
  int          errors = 0;

  sampadcacc_mc_if bus ();

  sampadcacc_mc #(.NUM_CH(4), .ADC_BITS(8), .SUM_BITS(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .sq_active    (sq_active),
    .sample       (sample),
    .sample_avail (sample_avail),
    .wb           (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    bus.wb_adr_i = {13'h0, a};
    bus.wb_dat_i = d;
    tick();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic wb_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
    bus.wb_adr_i = {13'h0, a};
    #1;
    check(tag, {24'h0, bus.wb_dat_o}, {24'h0, exp});
  endtask

  task automatic set_adc(input logic [7:0] c0, input logic [7:0] c1,
                         input logic [7:0] c2, input logic [7:0] c3);
    adc_data = {c3, c2, c1, c0};
  endtask

  initial begin
    logic [7:0]  w;
    logic [31:0] exp_s;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_sample", sample, 32'h0);
    check("rst_avail", {31'h0, sample_avail}, 32'h0);
    check("ack", {31'h0, bus.wb_ack_o}, 32'h1);
    wb_check("rst_status", 3'd0, 8'h00);
    wb_check("rst_acc_cnt", 3'd1, 8'h00);
    wb_check("rst_fw", 3'd2, 8'h08);
    wb_check("rst_fps", 3'd3, 8'h03);
    wb_check("rst_mask", 3'd4, 8'h01);
    wb_check("rst_init_hi", 3'd6, 8'h00);
    wb_check("reg7", 3'd7, 8'h00);
    tick();

    // Basic fill: four single-strobe windows on ch0
    wb_write(3'd0, 8'h01);
    wb_write(3'd2, 8'h00);
    wb_check("fw_zero_is_16", 3'd2, 8'h10);
    wb_write(3'd2, 8'h08);
    sq_active = 1'b1;
    adc_valid = 1'b1;
    set_adc(8'h11, 0, 0, 0); tick();
    set_adc(8'h22, 0, 0, 0); tick();
    set_adc(8'h33, 0, 0, 0); tick();
    set_adc(8'h44, 0, 0, 0); tick();
    check("fill_avail_early", {31'h0, sample_avail}, 32'h0);
    adc_valid = 1'b0;
    tick();
    check("fill_avail", {31'h0, sample_avail}, 32'h1);
    check("fill_sample", sample, 32'h11223344);
    tick();
    check("fill_avail_pulse", {31'h0, sample_avail}, 32'h0);

    // Summing with INIT = -2, one field per entry
    sq_active = 1'b0;
    tick();
    wb_write(3'd1, 8'd3);
    wb_write(3'd0, 8'h03);
    wb_write(3'd3, 8'h00);
    wb_write(3'd5, 8'hFE);
    wb_write(3'd6, 8'hFF);
    sq_active = 1'b1;
    adc_valid = 1'b1;
    set_adc(8'd10, 0, 0, 0);
    repeat (4) tick();
    adc_valid = 1'b0;
    tick();
    check("sum_avail", {31'h0, sample_avail}, 32'h1);
    check("sum_field", sample & 32'hFF, 32'd38);
    wb_check("sum_status", 3'd0, 8'h03);

    // Overflow saturates to 0xFF; W1C while active leaves config untouched
    sq_active = 1'b0;
    tick();
    wb_write(3'd5, 8'h00);
    wb_write(3'd6, 8'h00);
    sq_active = 1'b1;
    adc_valid = 1'b1;
    set_adc(8'h50, 0, 0, 0);
    repeat (4) tick();
    adc_valid = 1'b0;
    tick();
    check("ovf_field", sample & 32'hFF, 32'hFF);
    wb_check("ovf_status", 3'd0, 8'h13);
    wb_write(3'd0, 8'h10);
    wb_check("ovf_cleared", 3'd0, 8'h03);

    // Underflow: INIT = -300 plus 5 clamps to 0
    sq_active = 1'b0;
    tick();
    wb_write(3'd1, 8'd0);
    wb_write(3'd5, 8'hD4);
    wb_write(3'd6, 8'hFE);
    sq_active = 1'b1;
    adc_valid = 1'b1;
    set_adc(8'd5, 0, 0, 0);
    tick();
    adc_valid = 1'b0;
    tick();
    check("unf_avail", {31'h0, sample_avail}, 32'h1);
    check("unf_field", sample & 32'hFF, 32'h0);
    wb_check("unf_status", 3'd0, 8'h23);
    wb_write(3'd0, 8'h20);
    wb_check("unf_cleared", 3'd0, 8'h03);

    // Multi-channel: mask 0b1010, 13-bit fields, two fields per entry
    sq_active = 1'b0;
    tick();
    wb_write(3'd4, 8'h0A);
    wb_write(3'd2, 8'd13);
    wb_write(3'd3, 8'd1);
    wb_write(3'd5, 8'h00);
    wb_write(3'd6, 8'h00);
    sq_active = 1'b1;
    adc_valid = 1'b1;
    set_adc(8'd0, 8'd100, 8'd0, 8'd200);
    tick();
    adc_valid = 1'b0;
    tick();
    check("mc_avail_1", {31'h0, sample_avail}, 32'h0);
    check("mc_first", sample & 32'h1FFF, 32'd100);
    tick();
    check("mc_avail_2", {31'h0, sample_avail}, 32'h1);
    check("mc_sample", sample & 32'h03FF_FFFF, 32'h000C_80C8);
    tick();
    check("mc_avail_3", {31'h0, sample_avail}, 32'h0);
    wb_check("mc_status", 3'd0, 8'h03);

    // Overrun: four channels, a window end every cycle for nine cycles
    sq_active = 1'b0;
    tick();
    wb_write(3'd4, 8'h0F);
    wb_write(3'd2, 8'd8);
    wb_write(3'd3, 8'd3);
    sq_active = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      w = 8'(i);
      adc_valid = (i <= 9);
      set_adc({w[3:0], 4'h0}, {w[3:0], 4'h1}, {w[3:0], 4'h2}, {w[3:0], 4'h3});
      tick();
      check("ovr_avail", {31'h0, sample_avail}, {31'h0, (i == 5) || (i == 9) || (i == 13)});
      if (i == 5 || i == 9 || i == 13) begin
        exp_s = (i == 5) ? 32'h10111213 : (i == 9) ? 32'h50515253 : 32'h90919293;
        check("ovr_sample", sample, exp_s);
      end
    end
    adc_valid = 1'b0;
    wb_check("ovr_status", 3'd0, 8'h43);

    // Abort mid-drain, then resume with a fresh entry
    sq_active = 1'b0;
    tick();
    wb_write(3'd0, 8'h43);
    wb_check("ovr_cleared", 3'd0, 8'h03);
    sq_active = 1'b1;
    adc_valid = 1'b1;
    set_adc(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    tick();
    adc_valid = 1'b0;
    tick();
    tick();
    sq_active = 1'b0;
    tick();
    tick();
    check("abort_sample", sample, 32'h9293A0A1);
    check("abort_avail", {31'h0, sample_avail}, 32'h0);
    sq_active = 1'b1;
    adc_valid = 1'b1;
    set_adc(8'hB0, 8'hB1, 8'hB2, 8'hB3);
    tick();
    adc_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("resume_avail", {31'h0, sample_avail}, {31'h0, k == 4});
    end
    check("resume_sample", sample, 32'hB0B1B2B3);

    // Asynchronous reset between clock edges
    adc_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_avail", {31'h0, sample_avail}, 32'h0);
    check("arst_sample", sample, 32'h0);
    wb_check("arst_status", 3'd0, 8'h00);
    wb_check("arst_mask", 3'd4, 8'h01);
    adc_valid = 1'b0;
    sq_active = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_avail", {31'h0, sample_avail}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
